// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: PC register and fetch-request controller with redirect, stall and misaligned-target trap.
// Optional perf counters are enabled by defining FETCH_PC_PERF_EN.
module fetch_pc_ctrl #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] seq_pc,
    output logic [XLEN-1:0] pc,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_addr
`ifdef FETCH_PC_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);
    typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;
    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, trap_addr_q, trap_addr_d;
    logic            trap_valid_q, trap_valid_d;
    logic            redir_ok, redir_bad, handshake;
    assign redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign fetch_valid = (state_q == FETCH) && !stall;
    assign handshake = fetch_valid && fetch_ready;
    assign pc = pc_q;
    assign trap_valid = trap_valid_q;
    assign trap_addr = trap_addr_q;
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        trap_valid_d = 1'b0;
        trap_addr_d  = trap_addr_q;
        if (state_q == BOOT) begin
            state_d = FETCH;
        end else if (redir_ok) begin
            pc_d    = redirect_target;
            state_d = FETCH;
        end else if (redir_bad) begin
            trap_valid_d = 1'b1;
            trap_addr_d  = redirect_target;
            state_d      = HALT;
        end else if (handshake) begin
            pc_d = seq_pc;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            trap_valid_q <= 1'b0;
            trap_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            trap_valid_q <= trap_valid_d;
            trap_addr_q  <= trap_addr_d;
        end
    end
`ifdef FETCH_PC_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + {31'd0, handshake};
            stall_cnt_q <= stall_cnt_q + {31'd0, (state_q == FETCH) && stall};
        end
    end
    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    // Counters omitted; core behaviour is unchanged.
`endif
endmodule
